ddr3_bitpix_reader: RTL and testbench

//  Downstream partner of the DDR3 pixel writer. Streams a stored frame back out of DDR3 over Avalon-MM burst reads.

---
 rtl/ddr3_pix_pkg.sv | 20 ++
 rtl/ddr3_reader_fifo.sv | 62 ++++++
 rtl/ddr3_bitpix_reader.sv | 189 ++++++++++++++++++
 tb/tb_ddr3_bitpix_reader.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_pix_pkg.sv
// Shared types and constants for the DDR3 pixel reader: FSM states, bus widths
// and the byte-to-word address helper.
package ddr3_pix_pkg;

   localparam int DDR3_DATA_W = 256;
   localparam int DDR3_ADDR_W = 27;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CREDIT,
      ST_ISSUE,
      ST_DRAIN
   } rd_state_t;

   // Avalon addresses whole 256-bit words, so the byte address drops its 5 LSBs
   function automatic logic [DDR3_ADDR_W-1:0] ddr3_word_addr(input logic [31:0] byte_addr);
      return DDR3_ADDR_W'(byte_addr >> 5);
   endfunction

endpackage

// File: rtl/ddr3_reader_fifo.sv
// Single-clock show-ahead FIFO of 256-bit words. RAM read is registered into a
// head stage, so the oldest word is always presented on rd_data when rd_valid.
module ddr3_reader_fifo
   import ddr3_pix_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int CNT_W = $clog2(DEPTH + 2)
) (
   input  logic                   pclk,
   input  logic                   rst_n,
   input  logic                   wr_en,
   input  logic [DDR3_DATA_W-1:0] wr_data,
   input  logic                   rd_en,
   output logic [DDR3_DATA_W-1:0] rd_data,
   output logic                   rd_valid,
   output logic [CNT_W-1:0]       count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [DDR3_DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]       wr_ptr_reg;
   logic [PTR_W-1:0]       rd_ptr_reg;
   logic [CNT_W-1:0]       ram_count_reg;
   logic [DDR3_DATA_W-1:0] head_reg;
   logic                   head_valid_reg;
   logic                   fetch;

   // Refill the head stage when it is empty or being consumed this cycle
   assign fetch = (ram_count_reg != '0) && (!head_valid_reg || rd_en);

   always_ff @(posedge pclk) begin
      if (wr_en)
         mem[wr_ptr_reg] <= wr_data;
      if (fetch)
         head_reg <= mem[rd_ptr_reg];
   end

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         ram_count_reg  <= '0;
         head_valid_reg <= 1'b0;
      end else begin
         if (wr_en)
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (fetch)
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         ram_count_reg <= ram_count_reg + CNT_W'(wr_en) - CNT_W'(fetch);
         if (fetch)
            head_valid_reg <= 1'b1;
         else if (rd_en)
            head_valid_reg <= 1'b0;
      end
   end

   assign rd_data  = head_reg;
   assign rd_valid = head_valid_reg;
   assign count    = ram_count_reg + CNT_W'(head_valid_reg);

endmodule

// File: rtl/ddr3_bitpix_reader.sv
// Streams a stored frame out of DDR3 via credit-limited Avalon bursts and slices
// each 256-bit word LSB-first onto a valid/ready port. DDR3_READER_LOOP_EN: repeat frames.
module ddr3_bitpix_reader
   import ddr3_pix_pkg::*;
#(
   parameter int          OUT_WIDTH  = 16,
   parameter int          BURST_LEN  = 8,
   parameter int          NUM_WORDS  = 86400,
   parameter logic [31:0] START_ADDR = 32'h36000000,
   parameter int          FIFO_DEPTH = 64
) (
   input  logic                   ddr3_clk,
   input  logic                   ddr3_clk_reset_n,
   input  logic                   start,
   output logic                   busy,
   output logic [DDR3_ADDR_W-1:0] ddr3_read_address,
   output logic                   ddr3_read,
   output logic [7:0]             ddr3_burstcount,
   input  logic                   ddr3_waitrequest,
   input  logic [DDR3_DATA_W-1:0] ddr3_readdata,
   input  logic                   ddr3_readdatavalid,
   output logic [OUT_WIDTH-1:0]   out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   out_last,
   output logic [7:0]             fifo_level
);

   localparam int SLICES  = DDR3_DATA_W / OUT_WIDTH;
   localparam int SLICE_W = (SLICES > 1) ? $clog2(SLICES) : 1;
   localparam int REQ_W   = $clog2(NUM_WORDS + 1);
   localparam int CNT_W   = $clog2(FIFO_DEPTH + 2);
   localparam logic [DDR3_ADDR_W-1:0] BASE_WORD = ddr3_word_addr(START_ADDR);

   rd_state_t              state_reg;
   logic                   busy_reg;
   logic                   read_reg;
   logic [DDR3_ADDR_W-1:0] addr_reg;
   logic [REQ_W-1:0]       requested_reg;
   logic [CNT_W-1:0]       outstanding_reg;

   logic [DDR3_DATA_W-1:0] word_reg;
   logic [SLICE_W-1:0]     slice_idx_reg;
   logic [REQ_W-1:0]       pop_count_reg;
   logic                   last_word_reg;
   logic                   out_valid_reg;
   logic                   out_last_reg;

   logic                   accept;
   logic                   beat_in;
   logic                   credit_ok;
   logic                   last_burst;
   logic                   fire;
   logic                   last_slice;
   logic                   pop;
   logic [DDR3_DATA_W-1:0] fifo_dout;
   logic                   fifo_valid;
   logic [CNT_W-1:0]       fifo_count;

   assign accept     = read_reg && !ddr3_waitrequest;
   // Beats arriving while idle are left over from before a reset and are dropped
   assign beat_in    = ddr3_readdatavalid && (state_reg != ST_IDLE);
   assign credit_ok  = (int'(fifo_count) + int'(outstanding_reg) + BURST_LEN) <= FIFO_DEPTH;
   assign last_burst = (requested_reg + REQ_W'(BURST_LEN)) == REQ_W'(NUM_WORDS);

   ddr3_reader_fifo #(
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .pclk     (ddr3_clk),
      .rst_n    (ddr3_clk_reset_n),
      .wr_en    (beat_in),
      .wr_data  (ddr3_readdata),
      .rd_en    (pop),
      .rd_data  (fifo_dout),
      .rd_valid (fifo_valid),
      .count    (fifo_count)
   );

   always_ff @(posedge ddr3_clk or negedge ddr3_clk_reset_n) begin
      if (!ddr3_clk_reset_n) begin
         state_reg       <= ST_IDLE;
         busy_reg        <= 1'b0;
         read_reg        <= 1'b0;
         addr_reg        <= BASE_WORD;
         requested_reg   <= '0;
         outstanding_reg <= '0;
      end else begin
         outstanding_reg <= outstanding_reg
                            + (accept  ? CNT_W'(BURST_LEN) : CNT_W'(0))
                            - (beat_in ? CNT_W'(1)         : CNT_W'(0));
         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  addr_reg        <= BASE_WORD;
                  requested_reg   <= '0;
                  outstanding_reg <= '0;
                  busy_reg        <= 1'b1;
                  state_reg       <= ST_CREDIT;
               end
            end
            ST_CREDIT: begin
               if (credit_ok) begin
                  read_reg  <= 1'b1;
                  state_reg <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (accept) begin
                  read_reg <= 1'b0;
                  if (last_burst) begin
`ifdef DDR3_READER_LOOP_EN
                     addr_reg      <= BASE_WORD;
                     requested_reg <= '0;
                     state_reg     <= ST_CREDIT;
`else
                     addr_reg      <= addr_reg + DDR3_ADDR_W'(BURST_LEN);
                     requested_reg <= requested_reg + REQ_W'(BURST_LEN);
                     state_reg     <= ST_DRAIN;
`endif
                  end else begin
                     addr_reg      <= addr_reg + DDR3_ADDR_W'(BURST_LEN);
                     requested_reg <= requested_reg + REQ_W'(BURST_LEN);
                     state_reg     <= ST_CREDIT;
                  end
               end
            end
            ST_DRAIN: begin
               if (outstanding_reg == '0 && fifo_count == '0 && !out_valid_reg) begin
                  busy_reg  <= 1'b0;
                  state_reg <= ST_IDLE;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign fire       = out_valid_reg && out_ready;
   assign last_slice = slice_idx_reg == SLICE_W'(SLICES - 1);
   // Popping on the last-slice handshake keeps the output stream gap-free
   assign pop        = fifo_valid && (!out_valid_reg || (fire && last_slice));

   always_ff @(posedge ddr3_clk) begin
      if (pop)
         word_reg <= fifo_dout;
   end

   always_ff @(posedge ddr3_clk or negedge ddr3_clk_reset_n) begin
      if (!ddr3_clk_reset_n) begin
         slice_idx_reg <= '0;
         pop_count_reg <= '0;
         last_word_reg <= 1'b0;
         out_valid_reg <= 1'b0;
         out_last_reg  <= 1'b0;
      end else if (pop) begin
         out_valid_reg <= 1'b1;
         slice_idx_reg <= '0;
         last_word_reg <= pop_count_reg == REQ_W'(NUM_WORDS - 1);
         out_last_reg  <= (SLICES == 1) && (pop_count_reg == REQ_W'(NUM_WORDS - 1));
         pop_count_reg <= (pop_count_reg == REQ_W'(NUM_WORDS - 1)) ? '0
                                                                     : pop_count_reg + REQ_W'(1);
      end else if (fire) begin
         if (last_slice) begin
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
         end else begin
            slice_idx_reg <= slice_idx_reg + SLICE_W'(1);
            out_last_reg  <= last_word_reg && (slice_idx_reg == SLICE_W'(SLICES - 2));
         end
      end
   end

   logic [OUT_WIDTH-1:0] slice_arr [SLICES];

   for (genvar gi = 0; gi < SLICES; gi++) begin : g_slice
      assign slice_arr[gi] = word_reg[gi*OUT_WIDTH +: OUT_WIDTH];
   end

   assign out_data          = slice_arr[slice_idx_reg];
   assign out_valid         = out_valid_reg;
   assign out_last          = out_last_reg;
   assign busy              = busy_reg;
   assign ddr3_read         = read_reg;
   assign ddr3_read_address = addr_reg;
   assign ddr3_burstcount   = 8'(BURST_LEN);
   assign fifo_level        = 8'(fifo_count);

endmodule

// File: tb/tb_ddr3_bitpix_reader.sv
// Directed bench for ddr3_bitpix_reader with a 4-cycle-latency Avalon memory model.
// Slice n of a frame carries pixel index n, so expectations are simple counters.
`timescale 1ns/1ps
module tb_ddr3_bitpix_reader;
   localparam int          OUT_WIDTH    = 16;
   localparam int          BURST_LEN    = 8;
   localparam int          NUM_WORDS    = 64;
   localparam int          FIFO_DEPTH   = 32;
   localparam logic [31:0] START_ADDR   = 32'h36000000;
   localparam logic [26:0] BASE_W       = 27'h1B00000;
   localparam int          SLICES       = 256 / OUT_WIDTH;
   localparam int          FRAME_SLICES = NUM_WORDS * SLICES;
   localparam int          LAT          = 4;

   logic                 ddr3_clk = 1'b0;
   logic                 ddr3_clk_reset_n = 1'b0;
   logic                 start = 1'b0;
   logic                 busy;
   logic [26:0]          ddr3_read_address;
   logic                 ddr3_read;
   logic [7:0]           ddr3_burstcount;
   logic                 ddr3_waitrequest = 1'b0;
   logic [255:0]         ddr3_readdata = '0;
   logic                 ddr3_readdatavalid = 1'b0;
   logic [OUT_WIDTH-1:0] out_data;
   logic                 out_valid;
   logic                 out_ready = 1'b0;
   logic                 out_last;
   logic [7:0]           fifo_level;

   ddr3_bitpix_reader #(
      .OUT_WIDTH  (OUT_WIDTH),
      .BURST_LEN  (BURST_LEN),
      .NUM_WORDS  (NUM_WORDS),
      .START_ADDR (START_ADDR),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .ddr3_clk           (ddr3_clk),
      .ddr3_clk_reset_n   (ddr3_clk_reset_n),
      .start              (start),
      .busy               (busy),
      .ddr3_read_address  (ddr3_read_address),
      .ddr3_read          (ddr3_read),
      .ddr3_burstcount    (ddr3_burstcount),
      .ddr3_waitrequest   (ddr3_waitrequest),
      .ddr3_readdata      (ddr3_readdata),
      .ddr3_readdatavalid (ddr3_readdatavalid),
      .out_data           (out_data),
      .out_valid          (out_valid),
      .out_ready          (out_ready),
      .out_last           (out_last),
      .fifo_level         (fifo_level)
   );

   always #5 ddr3_clk = ~ddr3_clk;

   typedef struct {
      int          due;
      logic [26:0] a;
   } beat_t;

   beat_t q[$];
   int n_total = 0;
   int n_bad = 0;
   int cyc = 0;
   int exp_idx = 0;
   int n_last = 0;
   int burst_cnt = 0;
   int stall_burst = 3;
   int stall_left = 0;
   int n_stall = 0;
   int issued = 0;
   int delivered = 0;
   int stray_n = 0;
   bit ready_en = 1'b1;
   bit chk_credit = 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [255:0] beat_data(input logic [26:0] a);
      logic [255:0] d;
      int w;
      d = '0;
      w = int'(a - BASE_W);
      for (int k = 0; k < SLICES; k++)
         d[k*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(w * SLICES + k);
      return d;
   endfunction

   // One clock of bench activity, all done on the falling edge
   task automatic tick();
      beat_t b;
      @(negedge ddr3_clk);
      cyc++;
      if (chk_credit)
         check("credit_bound", 64'(int'(fifo_level) + issued - delivered <= FIFO_DEPTH), 64'd1);
      out_ready = ready_en;
      if (out_valid && out_ready) begin
         check("slice_data", out_data, 64'(OUT_WIDTH'(exp_idx % FRAME_SLICES)));
         check("slice_last", out_last, 64'((exp_idx % FRAME_SLICES) == FRAME_SLICES - 1));
         if (out_last)
            n_last++;
         exp_idx++;
      end
      ddr3_waitrequest = 1'b0;
      if (ddr3_read && burst_cnt == stall_burst && stall_left > 0) begin
         ddr3_waitrequest = 1'b1;
         stall_left--;
         n_stall++;
         check("stall_addr", ddr3_read_address, 64'(BASE_W + 27'(stall_burst * BURST_LEN)));
      end
      if (ddr3_read && !ddr3_waitrequest) begin
         check("burst_addr", ddr3_read_address,
               64'(BASE_W + 27'((burst_cnt * BURST_LEN) % NUM_WORDS)));
         check("burstcount", ddr3_burstcount, 64'(BURST_LEN));
         $display("burst %0d accepted addr=0x%07h cycle=%0d", burst_cnt, ddr3_read_address, cyc);
         for (int i = 0; i < BURST_LEN; i++) begin
            b.due = cyc + LAT + i;
            b.a   = ddr3_read_address + 27'(i);
            q.push_back(b);
         end
         burst_cnt++;
         issued += BURST_LEN;
      end
      ddr3_readdatavalid = 1'b0;
      if (stray_n > 0) begin
         ddr3_readdatavalid = 1'b1;
         ddr3_readdata      = '1;
         stray_n--;
      end else if (q.size() > 0 && q[0].due <= cyc) begin
         b = q.pop_front();
         ddr3_readdatavalid = 1'b1;
         ddr3_readdata      = beat_data(b.a);
         delivered++;
      end
   endtask

   task automatic begin_frame(input int stall);
      exp_idx    = 0;
      n_last     = 0;
      burst_cnt  = 0;
      stall_left = stall;
      n_stall    = 0;
      issued     = 0;
      delivered  = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("busy_on_start", busy, 64'd1);
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (busy && n < budget) begin
         tick();
         n++;
      end
      check("idle_in_budget", 64'(n < budget), 64'd1);
   endtask

   task automatic end_frame_checks();
      check("frame_slices", exp_idx, FRAME_SLICES);
      check("frame_lasts", n_last, 1);
      check("frame_bursts", burst_cnt, NUM_WORDS / BURST_LEN);
      check("frame_beats", delivered, NUM_WORDS);
      check("busy_after", busy, 0);
      check("fifo_after", fifo_level, 0);
      check("valid_after", out_valid, 0);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_read"}, ddr3_read, 0);
      check({tag, "_addr"}, ddr3_read_address, BASE_W);
      check({tag, "_valid"}, out_valid, 0);
      check({tag, "_last"}, out_last, 0);
      check({tag, "_level"}, fifo_level, 0);
   endtask

   initial begin
      repeat (3) tick();
      check_reset_values("reset");
      ddr3_clk_reset_n = 1'b1;
      tick();

      // Leftover beats while idle must not enter the FIFO
      stray_n = 3;
      repeat (6) tick();
      check("stray_level", fifo_level, 0);
      check("stray_valid", out_valid, 0);
      check("stray_busy", busy, 0);

`ifdef DDR3_READER_LOOP_EN
      begin
         int n;
         int drops;
         n = 0;
         drops = 0;
         ready_en = 1'b1;
         begin_frame(0);
         while (n_last < 3 && n < 8000) begin
            tick();
            if (!busy)
               drops++;
            n++;
         end
         check("loop_lasts", n_last, 3);
         check("loop_slices", exp_idx, 3 * FRAME_SLICES);
         check("loop_busy_drops", drops, 0);
         check("loop_busy", busy, 1);
         check("loop_wrapped", 64'(burst_cnt >= 3 * NUM_WORDS / BURST_LEN), 64'd1);
      end
`else
      // Full frame, stall on burst 3, plus an ignored start mid-frame
      ready_en = 1'b1;
      begin_frame(5);
      repeat (100) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      check("start_ignored_busy", busy, 1);
      wait_idle(5000);
      check("stall_cycles", n_stall, 5);
      end_frame_checks();

      // Consumer stalled: credit stops the requests at a full FIFO
      ready_en = 1'b0;
      chk_credit = 1'b1;
      begin_frame(0);
      repeat (500) tick();
      check("stall_level", fifo_level, FIFO_DEPTH - 1);
      check("stall_bursts", burst_cnt, FIFO_DEPTH / BURST_LEN);
      check("stall_valid", out_valid, 1);
      check("stall_held_data", out_data, 0);
      ready_en = 1'b1;
      wait_idle(5000);
      chk_credit = 1'b0;
      end_frame_checks();

      // Abort mid-frame with reset, then a clean frame
      begin_frame(0);
      repeat (60) tick();
      #2;
      ddr3_clk_reset_n = 1'b0;
      ddr3_readdatavalid = 1'b0;
      q.delete();
      #1;
      check_reset_values("abort");
      repeat (3) tick();
      ddr3_clk_reset_n = 1'b1;
      tick();
      begin_frame(0);
      check("restart_addr", ddr3_read_address, BASE_W);
      wait_idle(5000);
      end_frame_checks();
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
